// File: rtl/srdl2sv_widget_arbiter.sv
// Round-robin arbiter that shares one srdl2sv register-file access port
// between N_REQ bus widgets (e.g. AHB-Lite and a debug/JTAG widget).
//
// Each upstream port follows widget-interface semantics, flattened to
// vectors. A requester holds w_vld or r_vld until it sees its req_rdy
// strobe. One transaction is forwarded downstream at a time. A watchdog
// forces an error response if the register block stalls.
//
// Ports
//   HCLK, HRESET  clock and synchronous active-high reset
//   req_w_vld     per-requester write valid               [N_REQ]
//   req_r_vld     per-requester read valid                [N_REQ]
//   req_addr      per-requester address, slice [32*i+:32] [N_REQ*32]
//   req_w_data    per-requester write data                [N_REQ*BUS_BITS]
//   req_byte_en   per-requester byte enables              [N_REQ*BUS_BYTES]
//   req_rdy       per-requester completion strobe         [N_REQ]
//   req_err       per-requester error, qualified by rdy   [N_REQ]
//   req_r_data    shared read data, 0 when no rdy         [BUS_BITS]
//   dn_w_vld      downstream write valid
//   dn_r_vld      downstream read valid
//   dn_addr       downstream address                      [32]
//   dn_w_data     downstream write data                   [BUS_BITS]
//   dn_byte_en    downstream byte enables                 [BUS_BYTES]
//   dn_rdy        downstream completion
//   dn_err        downstream error, qualified by dn_rdy
//   dn_r_data     downstream read data                    [BUS_BITS]
module srdl2sv_widget_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned BUS_BITS       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned BUS_BYTES     = BUS_BITS / 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,

  input  logic [N_REQ-1:0]             req_w_vld,
  input  logic [N_REQ-1:0]             req_r_vld,
  input  logic [N_REQ*32-1:0]          req_addr,
  input  logic [N_REQ*BUS_BITS-1:0]    req_w_data,
  input  logic [N_REQ*BUS_BYTES-1:0]   req_byte_en,
  output logic [N_REQ-1:0]             req_rdy,
  output logic [N_REQ-1:0]             req_err,
  output logic [BUS_BITS-1:0]          req_r_data,

  output logic                         dn_w_vld,
  output logic                         dn_r_vld,
  output logic [31:0]                  dn_addr,
  output logic [BUS_BITS-1:0]          dn_w_data,
  output logic [BUS_BYTES-1:0]         dn_byte_en,
  input  logic                         dn_rdy,
  input  logic                         dn_err,
  input  logic [BUS_BITS-1:0]          dn_r_data
);

  localparam int unsigned GrantW = $clog2(N_REQ);

  // A zero TIMEOUT_CYCLES would give a zero-width timer; keep one bit so the
  // register stays legal, it is simply never compared.
  localparam int unsigned TimerW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TimerW-1:0] TimerLast =
      TimerW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerMax = {TimerW{1'b1}};

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e              state_q;
  logic [GrantW-1:0]   grant_q;
  logic [GrantW-1:0]   last_q;
  logic [TimerW-1:0]   timer_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first pending index after last_q, wrapping modulo N_REQ.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0]  pending;
  logic [GrantW-1:0] cand;
  logic [GrantW-1:0] pick;
  logic              pick_vld;

  assign pending = req_w_vld | req_r_vld;

  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = GrantW'((32'(last_q) + k) % N_REQ);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted requester's signals.
  // ---------------------------------------------------------------------------
  logic                 g_w_vld;
  logic                 g_r_vld;
  logic [31:0]          g_addr;
  logic [BUS_BITS-1:0]  g_w_data;
  logic [BUS_BYTES-1:0] g_byte_en;

  always_comb begin
    g_w_vld   = req_w_vld[grant_q];
    g_r_vld   = req_r_vld[grant_q];
    g_addr    = req_addr[32*grant_q +: 32];
    g_w_data  = req_w_data[BUS_BITS*grant_q +: BUS_BITS];
    g_byte_en = req_byte_en[BUS_BYTES*grant_q +: BUS_BYTES];
  end

  // ---------------------------------------------------------------------------
  // GRANT exit conditions. Outputs are suppressed while HRESET is high, so a
  // reset during GRANT never issues a response.
  // ---------------------------------------------------------------------------
  logic in_grant;
  logic illegal;
  logic complete;
  logic timeout;
  logic abort;
  logic respond;
  logic err_resp;
  logic done;

  always_comb begin
    in_grant = (state_q == StGrant) && !HRESET;
    // Nothing is presented downstream for an illegal request, so any dn_rdy
    // that cycle cannot belong to it; the illegal response takes precedence.
    illegal  = in_grant && g_w_vld && g_r_vld;
    complete = in_grant && !illegal && dn_rdy;
    timeout  = in_grant && !illegal && !dn_rdy && TimeoutEn && (timer_q == TimerLast);
    abort    = in_grant && !illegal && !dn_rdy && !timeout && !g_w_vld && !g_r_vld;
    respond  = illegal || complete || timeout;
    err_resp = illegal || timeout || (complete && dn_err);
    done     = respond || abort;
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    dn_w_vld   = in_grant && !illegal && g_w_vld;
    dn_r_vld   = in_grant && !illegal && g_r_vld;
    dn_addr    = in_grant ? g_addr    : '0;
    dn_w_data  = in_grant ? g_w_data  : '0;
    dn_byte_en = in_grant ? g_byte_en : '0;
  end

  always_comb begin
    req_rdy = '0;
    req_err = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_rdy[i] = respond && (grant_q == GrantW'(i));
      req_err[i] = respond && err_resp && (grant_q == GrantW'(i));
    end
    // Writes also return dn_r_data; timeouts and illegal requests return 0.
    req_r_data = complete ? dn_r_data : '0;
  end

  // ---------------------------------------------------------------------------
  // FSM, arbitration pointer and watchdog timer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GrantW'(N_REQ - 1);
      timer_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            grant_q <= pick;
            timer_q <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          // Saturate rather than wrap so a disabled or very long stall never
          // aliases back to a small count.
          if (timer_q != TimerMax) begin
            timer_q <= timer_q + TimerW'(1);
          end
          if (done) begin
            state_q <= StIdle;
            // Illegal requests also advance the pointer so a misbehaving
            // widget cannot starve the others.
            last_q  <= grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_srdl2sv_widget_arbiter.sv
module tb_srdl2sv_widget_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 4;

  logic             HCLK;
  logic             HRESET;
  logic [NREQ-1:0]  req_w_vld;
  logic [NREQ-1:0]  req_r_vld;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_w_data;
  logic [NREQ*4-1:0]  req_byte_en;
  logic [NREQ-1:0]  req_rdy;
  logic [NREQ-1:0]  req_err;
  logic [31:0]      req_r_data;
  logic             dn_w_vld;
  logic             dn_r_vld;
  logic [31:0]      dn_addr;
  logic [31:0]      dn_w_data;
  logic [3:0]       dn_byte_en;
  logic             dn_rdy;
  logic             dn_err;
  logic [31:0]      dn_r_data;

  srdl2sv_widget_arbiter #(
    .N_REQ         (NREQ),
    .BUS_BITS      (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req_w_vld  (req_w_vld),
    .req_r_vld  (req_r_vld),
    .req_addr   (req_addr),
    .req_w_data (req_w_data),
    .req_byte_en(req_byte_en),
    .req_rdy    (req_rdy),
    .req_err    (req_err),
    .req_r_data (req_r_data),
    .dn_w_vld   (dn_w_vld),
    .dn_r_vld   (dn_r_vld),
    .dn_addr    (dn_addr),
    .dn_w_data  (dn_w_data),
    .dn_byte_en (dn_byte_en),
    .dn_rdy     (dn_rdy),
    .dn_err     (dn_err),
    .dn_r_data  (dn_r_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: which requester owns the port (-1 when free), how many
  // GRANT cycles it has already spent, and who was served last.
  // ---------------------------------------------------------------------------
  int m_cur  = -1;
  int m_age  = 0;
  int m_last = NREQ - 1;
  int n_cur, n_age, n_last, m_idx, g;
  bit m_found, w, r;
  logic [NREQ-1:0] e_rdy, e_err;
  logic [31:0]     e_rdata;
  logic            e_w, e_r;

  always @(negedge HCLK) begin
    if (HRESET) begin
      m_cur  = -1;
      m_age  = 0;
      m_last = NREQ - 1;
    end else begin
      e_rdy = '0; e_err = '0; e_rdata = '0; e_w = 1'b0; e_r = 1'b0;
      n_cur = m_cur; n_age = m_age; n_last = m_last; g = 0;
      if (m_cur < 0) begin
        m_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          m_idx = (m_last + k) % NREQ;
          if (!m_found && (req_w_vld[m_idx] || req_r_vld[m_idx])) begin
            m_found = 1'b1;
            n_cur   = m_idx;
            n_age   = 0;
          end
        end
      end else begin
        g = m_cur;
        w = req_w_vld[g];
        r = req_r_vld[g];
        n_age = m_age + 1;
        if (w && r) begin
          e_rdy[g] = 1'b1; e_err[g] = 1'b1; n_cur = -1; n_last = g;
        end else begin
          e_w = w; e_r = r;
          if (dn_rdy) begin
            e_rdy[g] = 1'b1; e_err[g] = dn_err; e_rdata = dn_r_data;
            n_cur = -1; n_last = g;
          end else if (TO != 0 && m_age == TO - 1) begin
            e_rdy[g] = 1'b1; e_err[g] = 1'b1; n_cur = -1; n_last = g;
          end else if (!w && !r) begin
            n_cur = -1; n_last = g;
          end
        end
      end
      chk("model_dn_w_vld", 64'(dn_w_vld), 64'(e_w));
      chk("model_dn_r_vld", 64'(dn_r_vld), 64'(e_r));
      chk("model_req_rdy", 64'(req_rdy), 64'(e_rdy));
      chk("model_req_err", 64'(req_err), 64'(e_err));
      chk("model_req_r_data", 64'(req_r_data), 64'(e_rdata));
      if (e_w || e_r) begin
        chk("model_dn_addr", 64'(dn_addr), 64'(req_addr[32*g +: 32]));
        chk("model_dn_w_data", 64'(dn_w_data), 64'(req_w_data[32*g +: 32]));
        chk("model_dn_byte_en", 64'(dn_byte_en), 64'(req_byte_en[4*g +: 4]));
      end
      m_cur = n_cur; m_age = n_age; m_last = n_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. step() moves to just after the next edge; probe()
  // waits a little further so literal checks see settled outputs.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic probe();
    #2;
  endtask

  initial begin
    HRESET = 1'b1;
    req_w_vld = '0; req_r_vld = '0;
    req_addr = '0; req_w_data = '0; req_byte_en = '0;
    dn_rdy = 1'b0; dn_err = 1'b0; dn_r_data = '0;
    step(); step();
    HRESET = 1'b0;
    probe();
    chk("reset_dn_w_vld", 64'(dn_w_vld), 64'd0);
    chk("reset_dn_r_vld", 64'(dn_r_vld), 64'd0);
    chk("reset_dn_addr", 64'(dn_addr), 64'd0);
    chk("reset_req_rdy", 64'(req_rdy), 64'd0);
    chk("reset_req_r_data", 64'(req_r_data), 64'd0);

    // dn_rdy while idle is ignored
    step();
    dn_rdy = 1'b1; dn_err = 1'b1; dn_r_data = 32'h1234;
    probe();
    chk("idle_dn_rdy_req_rdy", 64'(req_rdy), 64'd0);
    chk("idle_dn_rdy_r_data", 64'(req_r_data), 64'd0);

    // Single read by requester 0 with two wait states
    step();
    dn_rdy = 1'b0; dn_err = 1'b0; dn_r_data = '0;
    req_r_vld = 3'b001; req_addr[31:0] = 32'h10;
    probe();
    chk("rd_c0_dn_r_vld", 64'(dn_r_vld), 64'd0);
    step(); probe();
    chk("rd_c1_dn_r_vld", 64'(dn_r_vld), 64'd1);
    chk("rd_c1_dn_addr", 64'(dn_addr), 64'h10);
    chk("rd_c1_req_rdy", 64'(req_rdy), 64'd0);
    step(); probe();
    chk("rd_c2_dn_r_vld", 64'(dn_r_vld), 64'd1);
    step();
    dn_rdy = 1'b1; dn_r_data = 32'hDEADBEEF;
    probe();
    chk("rd_c3_dn_r_vld", 64'(dn_r_vld), 64'd1);
    chk("rd_c3_req_rdy", 64'(req_rdy), 64'b001);
    chk("rd_c3_req_err", 64'(req_err), 64'd0);
    chk("rd_c3_r_data", 64'(req_r_data), 64'hDEADBEEF);
    step();
    req_r_vld = '0; dn_rdy = 1'b0; dn_r_data = '0;
    probe();
    chk("rd_c4_req_rdy", 64'(req_rdy), 64'd0);
    chk("rd_c4_dn_r_vld", 64'(dn_r_vld), 64'd0);

    // Error pass-through: requester 1 writes, requester 0 also pending
    step();
    req_w_vld = 3'b010; req_r_vld = 3'b001;
    req_addr[63:32] = 32'h24; req_w_data[63:32] = 32'hA5A50001; req_byte_en[7:4] = 4'b0011;
    dn_rdy = 1'b1; dn_err = 1'b1; dn_r_data = 32'h55;
    step(); probe();
    chk("err_req_rdy", 64'(req_rdy), 64'b010);
    chk("err_req_err", 64'(req_err), 64'b010);
    chk("err_dn_w_data", 64'(dn_w_data), 64'hA5A50001);
    chk("err_dn_byte_en", 64'(dn_byte_en), 64'b0011);
    chk("err_r_data", 64'(req_r_data), 64'h55);
    step();
    req_w_vld = '0; dn_err = 1'b0; dn_r_data = 32'h77;
    probe();
    chk("err_gap_req_rdy", 64'(req_rdy), 64'd0);
    step(); probe();
    chk("err_next_req_rdy", 64'(req_rdy), 64'b001);
    chk("err_next_req_err", 64'(req_err), 64'd0);
    step();
    req_r_vld = '0; dn_rdy = 1'b0; dn_r_data = '0;

    // Timeout: requester 1 writes, downstream never answers
    step();
    req_w_vld = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      step(); probe();
      chk("to_wait_req_rdy", 64'(req_rdy), 64'd0);
      chk("to_wait_dn_w_vld", 64'(dn_w_vld), 64'd1);
    end
    step(); probe();
    chk("to_req_rdy", 64'(req_rdy), 64'b010);
    chk("to_req_err", 64'(req_err), 64'b010);
    chk("to_r_data", 64'(req_r_data), 64'd0);
    step(); probe();
    chk("to_after_dn_w_vld", 64'(dn_w_vld), 64'd0);
    chk("to_after_req_rdy", 64'(req_rdy), 64'd0);
    // Still held, so it is granted again; dropping vld now is an abort
    step();
    req_w_vld = '0;
    probe();
    chk("abort_req_rdy", 64'(req_rdy), 64'd0);
    chk("abort_dn_w_vld", 64'(dn_w_vld), 64'd0);
    step(); probe();
    chk("abort_idle_req_rdy", 64'(req_rdy), 64'd0);

    // Illegal: requester 0 asserts write and read together
    step();
    req_w_vld = 3'b001; req_r_vld = 3'b001;
    step(); probe();
    chk("ill_dn_w_vld", 64'(dn_w_vld), 64'd0);
    chk("ill_dn_r_vld", 64'(dn_r_vld), 64'd0);
    chk("ill_req_rdy", 64'(req_rdy), 64'b001);
    chk("ill_req_err", 64'(req_err), 64'b001);
    step();
    req_w_vld = '0; req_r_vld = '0;
    probe();
    chk("ill_after_req_rdy", 64'(req_rdy), 64'd0);

    // Reset in the middle of a GRANT
    step();
    req_r_vld = 3'b100;
    step(); probe();
    chk("rst_grant_dn_r_vld", 64'(dn_r_vld), 64'd1);
    step();
    HRESET = 1'b1; req_r_vld = '0;
    step();
    HRESET = 1'b0;
    probe();
    chk("rst_after_dn_r_vld", 64'(dn_r_vld), 64'd0);
    chk("rst_after_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_after_dn_addr", 64'(dn_addr), 64'd0);

    // Fairness: everyone holds w_vld, downstream always ready
    req_w_vld = 3'b111; dn_rdy = 1'b1; dn_r_data = 32'hC0DE;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[32*i +: 32]   = 32'h100 + 32'(4 * i);
      req_w_data[32*i +: 32] = 32'h11111111 * 32'(i + 1);
    end
    req_byte_en = 12'h81F;
    for (int i = 0; i < 12; i++) begin
      step(); probe();
      if (i % 2 == 0) begin
        chk("fair_req_rdy", 64'(req_rdy), 64'(1 << ((i / 2) % 3)));
        chk("fair_dn_addr", 64'(dn_addr), 64'(32'h100 + 32'(4 * ((i / 2) % 3))));
      end else begin
        chk("fair_gap_req_rdy", 64'(req_rdy), 64'd0);
      end
    end
    step();
    req_w_vld = '0; dn_rdy = 1'b0; dn_r_data = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
